control_unit: RTL and testbench

Instruction-sequencing FSM for the lab processor, directly upstream of the 16×16 register file. Holds the program counter and instruction register, fetches 16-bit words from a synchronous instruction ROM, and produces the register-file read/write addresses and enables. It also drives the data-memory address/write strobe, the write-back mux select and the ALU function select for each instruction.

---
 rtl/processor_pkg.sv | 56 +++++
 rtl/program_counter.sv | 22 ++
 rtl/control_unit.sv | 112 +++++++++++
 tb/tb_control_unit.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/processor_pkg.sv
// Shared definitions for the lab processor: FSM states, opcodes, ALU codes
// and instruction-register field positions.
package processor_pkg;

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  typedef enum logic [3:0] {
    OP_NOOP  = 4'h0,
    OP_STORE = 4'h1,
    OP_LOAD  = 4'h2,
    OP_ADD   = 4'h3,
    OP_SUB   = 4'h4,
    OP_HALT  = 4'h5
  } opcode_t;

  typedef enum logic [2:0] {
    ALU_ZERO = 3'd0,
    ALU_ADD  = 3'd1,
    ALU_SUB  = 3'd2
  } alu_t;

  localparam int IR_OP_HI = 15;
  localparam int IR_OP_LO = 12;
  localparam int IR_DA_HI = 11;
  localparam int IR_DA_LO = 4;
  localparam int IR_RA_HI = 11;
  localparam int IR_RA_LO = 8;
  localparam int IR_RB_HI = 7;
  localparam int IR_RB_LO = 4;
  localparam int IR_RD_HI = 3;
  localparam int IR_RD_LO = 0;

  // Unassigned opcodes fall through to NOOP.
  function automatic state_t exec_state(input logic [3:0] opcode);
    case (opcode)
      OP_STORE: return S_STORE;
      OP_LOAD:  return S_LOAD_A;
      OP_ADD:   return S_ADD;
      OP_SUB:   return S_SUB;
      OP_HALT:  return S_HALT;
      default:  return S_NOOP;
    endcase
  endfunction

endpackage

// File: rtl/program_counter.sv
// Program counter: synchronous clear, increment, natural PC_W-bit wrap.
module program_counter #(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            inc,
  output logic [PC_W-1:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
    end else if (clr) begin
      pc <= '0;
    end else if (inc) begin
      pc <= pc + PC_W'(1);
    end
  end

endmodule

// File: rtl/control_unit.sv
// Instruction-sequencing FSM: owns the IR, drives the PC and produces
// register-file, data-memory and ALU controls as Moore outputs.
module control_unit
  import processor_pkg::*;
#(
  parameter int PC_W = 8,
  parameter int DA_W = 8
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic [15:0]     IM_data,
  output logic [PC_W-1:0] IM_addr,
  output logic [DA_W-1:0] D_addr,
  output logic            D_wr,
  output logic            RF_s,
  output logic [3:0]      RF_W_addr,
  output logic            RF_W_en,
  output logic [3:0]      RF_Ra_addr,
  output logic            RF_Ra_en,
  output logic [3:0]      RF_Rb_addr,
  output logic            RF_Rb_en,
  output logic [2:0]      ALU_s,
  output logic [3:0]      State
);

  state_t          state;
  state_t          state_next;
  logic [15:0]     ir;
  logic            pc_clr;
  logic            pc_inc;
  logic [PC_W-1:0] pc;

  program_counter #(.PC_W(PC_W)) u_pc (
    .clk   (Clk),
    .rst_n (Rst),
    .clr   (pc_clr),
    .inc   (pc_inc),
    .pc    (pc)
  );

  assign pc_clr  = (state == S_INIT);
  assign pc_inc  = (state == S_FETCH);
  assign IM_addr = pc;
  assign State   = state;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state <= S_INIT;
      ir    <= '0;
    end else begin
      state <= state_next;
      if (state == S_INIT) begin
        ir <= '0;
      end else if (state == S_FETCH) begin
        ir <= IM_data;
      end
    end
  end

  always_comb begin
    state_next = state;
    D_addr     = '0;
    D_wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_addr  = '0;
    RF_W_en    = 1'b0;
    RF_Ra_addr = '0;
    RF_Ra_en   = 1'b0;
    RF_Rb_addr = '0;
    RF_Rb_en   = 1'b0;
    ALU_s      = ALU_ZERO;

    unique case (state)
      S_INIT:   state_next = S_FETCH;
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: state_next = exec_state(ir[IR_OP_HI:IR_OP_LO]);
      S_NOOP:   state_next = S_FETCH;
      S_LOAD_A: begin
        state_next = S_LOAD_B;
        D_addr     = DA_W'(ir[IR_DA_HI:IR_DA_LO]);
      end
      // Memory data is valid in the second LOAD cycle; write-back happens here.
      S_LOAD_B: begin
        state_next = S_FETCH;
        D_addr     = DA_W'(ir[IR_DA_HI:IR_DA_LO]);
        RF_s       = 1'b1;
        RF_W_addr  = ir[IR_RD_HI:IR_RD_LO];
        RF_W_en    = 1'b1;
      end
      S_STORE: begin
        state_next = S_FETCH;
        D_addr     = DA_W'(ir[IR_DA_HI:IR_DA_LO]);
        RF_Ra_addr = ir[IR_RD_HI:IR_RD_LO];
        RF_Ra_en   = 1'b1;
        D_wr       = 1'b1;
      end
      S_ADD, S_SUB: begin
        state_next = S_FETCH;
        RF_Ra_addr = ir[IR_RA_HI:IR_RA_LO];
        RF_Ra_en   = 1'b1;
        RF_Rb_addr = ir[IR_RB_HI:IR_RB_LO];
        RF_Rb_en   = 1'b1;
        ALU_s      = (state == S_ADD) ? ALU_ADD : ALU_SUB;
        RF_W_addr  = ir[IR_RD_HI:IR_RD_LO];
        RF_W_en    = 1'b1;
      end
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_INIT;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed scenarios plus random
// programs compared against an instruction-level model of the ISA.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] im_data;
  logic [7:0]  im_addr, d_addr;
  logic        d_wr, rf_s, rf_w_en, rf_ra_en, rf_rb_en;
  logic [3:0]  rf_w_addr, rf_ra_addr, rf_rb_addr, state;
  logic [2:0]  alu_s;

  logic [1:0]  w_im_addr;
  logic [7:0]  w_d_addr;
  logic        w_d_wr, w_rf_s, w_rf_w_en, w_rf_ra_en, w_rf_rb_en;
  logic [3:0]  w_rf_w_addr, w_rf_ra_addr, w_rf_rb_addr, w_state;
  logic [2:0]  w_alu_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  control_unit #(.PC_W(8), .DA_W(8)) dut (
    .Clk(clk), .Rst(rst_n), .IM_data(im_data), .IM_addr(im_addr),
    .D_addr(d_addr), .D_wr(d_wr), .RF_s(rf_s), .RF_W_addr(rf_w_addr),
    .RF_W_en(rf_w_en), .RF_Ra_addr(rf_ra_addr), .RF_Ra_en(rf_ra_en),
    .RF_Rb_addr(rf_rb_addr), .RF_Rb_en(rf_rb_en), .ALU_s(alu_s), .State(state)
  );

  control_unit #(.PC_W(2), .DA_W(8)) u_wrap (
    .Clk(clk), .Rst(rst_n), .IM_data(16'h0000), .IM_addr(w_im_addr),
    .D_addr(w_d_addr), .D_wr(w_d_wr), .RF_s(w_rf_s), .RF_W_addr(w_rf_w_addr),
    .RF_W_en(w_rf_w_en), .RF_Ra_addr(w_rf_ra_addr), .RF_Ra_en(w_rf_ra_en),
    .RF_Rb_addr(w_rf_rb_addr), .RF_Rb_en(w_rf_rb_en), .ALU_s(w_alu_s), .State(w_state)
  );

  // Environment: synchronous instruction ROM, register file, synchronous data memory.
  logic [15:0] rom     [256];
  logic [15:0] rf_init [16];
  logic [15:0] dm_init [256];
  logic [15:0] rf_env  [16];
  logic [15:0] dm_env  [256];
  logic [15:0] dq;
  logic        load_init = 1'b0;
  int          wen_total = 0;
  int          strobe_total = 0;

  always @(posedge clk) im_data <= rom[im_addr];

  always @(posedge clk) begin
    logic [15:0] a, b;
    a = rf_ra_en ? rf_env[rf_ra_addr] : 16'h0000;
    b = rf_rb_en ? rf_env[rf_rb_addr] : 16'h0000;
    if (load_init) begin
      for (int i = 0; i < 16; i++) rf_env[i] <= rf_init[i];
      for (int i = 0; i < 256; i++) dm_env[i] <= dm_init[i];
    end else begin
      dq <= dm_env[d_addr];
      if (d_wr) dm_env[d_addr] <= a;
      if (rf_w_en)
        rf_env[rf_w_addr] <= rf_s ? dq :
                             (alu_s == 3'd1) ? a + b :
                             (alu_s == 3'd2) ? a - b : 16'h0000;
    end
  end

  always @(posedge clk) begin
    if (rf_w_en) wen_total <= wen_total + 1;
    if (d_wr || rf_w_en || rf_ra_en || rf_rb_en || rf_s) strobe_total <= strobe_total + 1;
  end

  // Instruction-level model state
  logic [15:0] m_rf [16];
  logic [15:0] m_dm [256];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
  endtask

  task automatic randomize_data();
    for (int i = 0; i < 16; i++) rf_init[i] = 16'($urandom);
    for (int i = 0; i < 256; i++) dm_init[i] = 16'($urandom);
  endtask

  task automatic apply_reset(input int hold);
    rst_n = 1'b0;
    load_init = 1'b1;
    tick();
    load_init = 1'b0;
    repeat (hold) tick();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Executes the program in rom; returns the number of rising edges after
  // reset release at which the HALT state is first visible.
  task automatic model_run(output int edges);
    int          pc;
    logic [15:0] w;
    bit          done;
    for (int i = 0; i < 16; i++) m_rf[i] = rf_init[i];
    for (int i = 0; i < 256; i++) m_dm[i] = dm_init[i];
    pc = 0;
    edges = 1;
    done = 0;
    for (int n = 0; n < 256 && !done; n++) begin
      w = rom[pc];
      pc = (pc + 1) % 256;
      case (w[15:12])
        4'h1: begin m_dm[w[11:4]] = m_rf[w[3:0]]; edges += 3; end
        4'h2: begin m_rf[w[3:0]] = m_dm[w[11:4]]; edges += 4; end
        4'h3: begin m_rf[w[3:0]] = m_rf[w[11:8]] + m_rf[w[7:4]]; edges += 3; end
        4'h4: begin m_rf[w[3:0]] = m_rf[w[11:8]] - m_rf[w[7:4]]; edges += 3; end
        4'h5: begin edges += 2; done = 1; end
        default: edges += 3;
      endcase
    end
  endtask

  task automatic test_reset();
    logic [59:0] outs;
    clear_rom();
    rom[0] = 16'h3123;
    rst_n = 1'b0;
    repeat (3) tick();
    outs = {im_addr, d_addr, d_wr, rf_s, rf_w_addr, rf_w_en, rf_ra_addr, rf_ra_en,
            rf_rb_addr, rf_rb_en, alu_s, state, 16'h0000};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0", outs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (state !== 4'd0) begin errors++; $display("FAIL reset_release_state: got %0d required 0", state); end
    tick();
    checks++;
    if (state !== 4'd1 || im_addr !== 8'd0) begin
      errors++; $display("FAIL reset_seq1: state %0d pc %0d required 1/0", state, im_addr);
    end
    tick();
    checks++;
    if (state !== 4'd2 || im_addr !== 8'd1) begin
      errors++; $display("FAIL reset_seq2: state %0d pc %0d required 2/1", state, im_addr);
    end
    tick();
    checks++;
    if (state !== 4'd7) begin errors++; $display("FAIL reset_seq3: state %0d required 7", state); end
  endtask

  task automatic test_add();
    logic [15:0] exp;
    clear_rom();
    rom[0] = 16'h3125;
    randomize_data();
    exp = rf_init[1] + rf_init[2];
    apply_reset(2);
    repeat (3) tick();
    checks++;
    if (state !== 4'd7 || rf_ra_addr !== 4'd1 || rf_rb_addr !== 4'd2 || rf_w_addr !== 4'd5 ||
        rf_w_en !== 1'b1 || alu_s !== 3'd1 || rf_s !== 1'b0 || rf_ra_en !== 1'b1 ||
        rf_rb_en !== 1'b1 || d_wr !== 1'b0) begin
      errors++;
      $display("FAIL add_controls: st %0d ra %0d rb %0d w %0d wen %b alu %0d s %b raen %b rben %b dwr %b",
               state, rf_ra_addr, rf_rb_addr, rf_w_addr, rf_w_en, alu_s, rf_s, rf_ra_en, rf_rb_en, d_wr);
    end
    tick();
    checks++;
    if (state !== 4'd1 || im_addr !== 8'd1) begin
      errors++; $display("FAIL add_next_fetch: state %0d pc %0d required 1/1", state, im_addr);
    end
    checks++;
    if (rf_env[5] !== exp) begin errors++; $display("FAIL add_result: got %h required %h", rf_env[5], exp); end
  endtask

  task automatic test_load_store();
    logic [15:0] x;
    clear_rom();
    rom[0] = 16'h20A3;
    rom[1] = 16'h10B3;
    rom[2] = 16'h5000;
    randomize_data();
    x = dm_init[8'h0A];
    apply_reset(2);
    repeat (3) tick();
    checks++;
    if (state !== 4'd4 || d_addr !== 8'h0A || rf_w_en !== 1'b0 || d_wr !== 1'b0) begin
      errors++; $display("FAIL load_a: st %0d da %h wen %b dwr %b", state, d_addr, rf_w_en, d_wr);
    end
    tick();
    checks++;
    if (state !== 4'd5 || d_addr !== 8'h0A || rf_s !== 1'b1 || rf_w_addr !== 4'd3 || rf_w_en !== 1'b1) begin
      errors++; $display("FAIL load_b: st %0d da %h s %b w %0d wen %b", state, d_addr, rf_s, rf_w_addr, rf_w_en);
    end
    tick();
    checks++;
    if (state !== 4'd1) begin errors++; $display("FAIL load_cycles: state %0d required 1", state); end
    repeat (2) tick();
    checks++;
    if (state !== 4'd6 || d_addr !== 8'h0B || rf_ra_addr !== 4'd3 || rf_ra_en !== 1'b1 ||
        d_wr !== 1'b1 || rf_w_en !== 1'b0) begin
      errors++; $display("FAIL store: st %0d da %h ra %0d raen %b dwr %b wen %b",
                         state, d_addr, rf_ra_addr, rf_ra_en, d_wr, rf_w_en);
    end
    tick();
    checks++;
    if (state !== 4'd1 || im_addr !== 8'd2) begin
      errors++; $display("FAIL store_cycles: state %0d pc %0d required 1/2", state, im_addr);
    end
    checks++;
    if (rf_env[3] !== x || dm_env[8'h0B] !== x) begin
      errors++; $display("FAIL load_store_data: r3 %h m0B %h required %h", rf_env[3], dm_env[8'h0B], x);
    end
  endtask

  task automatic test_illegal_halt();
    int snap;
    clear_rom();
    rom[0] = 16'hF000;
    rom[1] = 16'h5000;
    apply_reset(2);
    repeat (3) tick();
    checks++;
    if (state !== 4'd3 || {d_wr, rf_s, rf_w_en, rf_ra_en, rf_rb_en} !== 5'b0 || alu_s !== 3'd0) begin
      errors++; $display("FAIL illegal_noop: state %0d strobes %b", state, {d_wr, rf_s, rf_w_en, rf_ra_en, rf_rb_en});
    end
    repeat (3) tick();
    checks++;
    if (state !== 4'd9) begin errors++; $display("FAIL halt_enter: state %0d required 9", state); end
    snap = strobe_total;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (state !== 4'd9 || im_addr !== 8'd2) begin
        errors++; $display("FAIL halt_hold: cycle %0d state %0d pc %0d required 9/2", i, state, im_addr);
      end
    end
    checks++;
    if (strobe_total !== snap) begin
      errors++; $display("FAIL halt_strobes: %0d strobe cycles required 0", strobe_total - snap);
    end
  endtask

  task automatic test_reset_mid_load();
    int snap;
    clear_rom();
    rom[0] = 16'h20A3;
    apply_reset(2);
    repeat (3) tick();
    checks++;
    if (state !== 4'd4) begin errors++; $display("FAIL midload_reach: state %0d required 4", state); end
    snap = wen_total;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (state !== 4'd0 || im_addr !== 8'd0 || rf_w_en !== 1'b0 || d_addr !== 8'd0) begin
      errors++; $display("FAIL midload_async: state %0d pc %0d wen %b da %h", state, im_addr, rf_w_en, d_addr);
    end
    repeat (2) tick();
    checks++;
    if (wen_total !== snap) begin errors++; $display("FAIL midload_wen: %0d writes required 0", wen_total - snap); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (state !== 4'd1 || im_addr !== 8'd0) begin
      errors++; $display("FAIL midload_restart: state %0d pc %0d required 1/0", state, im_addr);
    end
    repeat (2) tick();
    checks++;
    if (state !== 4'd4 || im_addr !== 8'd1) begin
      errors++; $display("FAIL midload_refetch: state %0d pc %0d required 4/1", state, im_addr);
    end
  endtask

  task automatic test_pc_wrap();
    logic [1:0] exp;
    apply_reset(2);
    for (int k = 1; k <= 13; k++) begin
      tick();
      exp = (k >= 2) ? 2'(((k - 2) / 3 + 1) % 4) : 2'd0;
      checks++;
      if (w_im_addr !== exp) begin
        errors++; $display("FAIL pc_wrap: cycle %0d pc %0d required %0d", k, w_im_addr, exp);
      end
    end
  endtask

  task automatic test_random_program(input int iter);
    int exp_edges, n, bad;
    clear_rom();
    for (int i = 0; i < 20; i++) begin
      logic [15:0] w;
      w = 16'($urandom);
      case ($urandom_range(0, 6))
        0: w[15:12] = 4'h0;
        1: begin w[15:12] = 4'h1; w[11:4] = 8'($urandom_range(0, 15)); end
        2: begin w[15:12] = 4'h2; w[11:4] = 8'($urandom_range(0, 15)); end
        3, 6: w[15:12] = 4'h3;
        4: w[15:12] = 4'h4;
        default: w[15:12] = 4'($urandom_range(6, 15));
      endcase
      rom[i] = w;
    end
    rom[20] = 16'h5000;
    randomize_data();
    model_run(exp_edges);
    apply_reset(2);
    n = 0;
    while (state !== 4'd9 && n < 400) begin
      tick();
      n++;
    end
    checks++;
    if (n !== exp_edges) begin
      errors++; $display("FAIL rand%0d_cycles: halt after %0d edges required %0d", iter, n, exp_edges);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rf_env[i] !== m_rf[i]) begin
        errors++; $display("FAIL rand%0d_reg%0d: got %h required %h", iter, i, rf_env[i], m_rf[i]);
      end
    end
    bad = 0;
    for (int i = 0; i < 256; i++) if (dm_env[i] !== m_dm[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL rand%0d_dmem: %0d words differ required 0", iter, bad);
    end
  endtask

  initial begin
    clear_rom();
    randomize_data();
    test_reset();
    test_add();
    test_load_store();
    test_illegal_halt();
    test_reset_mid_load();
    test_pc_wrap();
    for (int r = 0; r < 4; r++) test_random_program(r);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
